imem_loader: RTL and testbench

Byte-stream program loader that sits directly upstream of the 32-bit instruction BRAM and drives its write port. It accepts a length-prefixed little-endian byte stream over a valid/ready handshake, packs bytes into 32-bit words, and issues one single-cycle write per word at consecutive word addresses from 0. It holds the rv32i core stalled until a complete, optionally checksummed, image is in memory.

---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/imem_loader_byte_packer32.sv | 35 +++
 rtl/imem_loader.sv | 127 ++++++++++++
 tb/tb_imem_loader.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Holds the loader state encodings and the BRAM word geometry.
package imem_loader_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int RAM_SIZE_WORDS = 1024;

  typedef enum logic [2:0] {
    LDR_IDLE  = 3'd0,
    LDR_LEN   = 3'd1,
    LDR_DATA  = 3'd2,
    LDR_CHECK = 3'd3,
    LDR_DONE  = 3'd4,
    LDR_ERROR = 3'd5
  } ldr_state_e;

endpackage

// File: rtl/imem_loader_byte_packer32.sv
// Packs a little-endian byte stream into 32-bit words. word_valid flags the
// 4th byte; word is then the complete word including that incoming byte.
module byte_packer32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  idx;
  logic [23:0] low;

  // The top byte is never stored: it is forwarded straight into word.
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      idx <= 2'd0;
      low <= 24'd0;
    end else if (byte_en) begin
      case (idx)
        2'd0:    low[7:0]   <= byte_in;
        2'd1:    low[15:8]  <= byte_in;
        2'd2:    low[23:16] <= byte_in;
        default: low        <= low;
      endcase
      idx <= idx + 2'd1;
    end
  end

  assign word_valid = byte_en && (idx == 2'd3);
  assign word       = {byte_in, low};

endmodule

// File: rtl/imem_loader.sv
// Length-prefixed byte-stream loader driving the instruction BRAM write port.
// Define LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_WORDS  = RAM_SIZE_WORDS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            s_byte,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [DATA_WIDTH-1:0] w_dat,
  output logic                  w_enb,
  output logic [ADDR_WIDTH:0]   word_cnt,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  localparam int CW = ADDR_WIDTH + 1;

`ifdef LOADER_CHECKSUM_EN
  localparam ldr_state_e FINAL_STATE = LDR_CHECK;
`else
  localparam ldr_state_e FINAL_STATE = LDR_DONE;
`endif

  ldr_state_e     state;
  logic [CW-1:0]  len_words;
  logic [CW-1:0]  word_cnt_nxt;
  logic           accept;
  logic           restartable;
  logic           pk_en;
  logic           pk_clear;
  logic           pk_valid;
  logic [31:0]    pk_word;

  assign s_ready      = (state == LDR_LEN) || (state == LDR_DATA) || (state == LDR_CHECK);
  assign done         = (state == LDR_DONE);
  assign error        = (state == LDR_ERROR);
  assign cpu_hold     = (state != LDR_DONE);
  assign accept       = s_valid && s_ready;
  assign restartable  = (state == LDR_IDLE) || (state == LDR_DONE) || (state == LDR_ERROR);
  assign pk_en        = accept && ((state == LDR_LEN) || (state == LDR_DATA));
  assign pk_clear     = start && restartable;
  assign word_cnt_nxt = word_cnt + CW'(1);

  // One packer serves both the length prefix and the payload words.
  byte_packer32 u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (pk_clear),
    .byte_en    (pk_en),
    .byte_in    (s_byte),
    .word_valid (pk_valid),
    .word       (pk_word)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] checksum;

  always_ff @(posedge clk) begin
    if (!rst || pk_clear) begin
      checksum <= 8'd0;
    end else if (accept && (state == LDR_DATA)) begin
      checksum <= checksum + s_byte;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= LDR_IDLE;
      w_enb     <= 1'b0;
      w_addr    <= '0;
      w_dat     <= '0;
      word_cnt  <= '0;
      len_words <= '0;
    end else begin
      w_enb <= 1'b0;
      case (state)
        LDR_IDLE, LDR_DONE, LDR_ERROR: begin
          if (start) begin
            state    <= LDR_LEN;
            word_cnt <= '0;
          end
        end
        LDR_LEN: begin
          if (pk_valid) begin
            if (pk_word > 32'(MAX_WORDS)) begin
              state <= LDR_ERROR;
            end else if (pk_word == 32'd0) begin
              state <= FINAL_STATE;
            end else begin
              state     <= LDR_DATA;
              len_words <= pk_word[CW-1:0];
            end
          end
        end
        LDR_DATA: begin
          if (pk_valid) begin
            w_enb    <= 1'b1;
            w_addr   <= word_cnt[ADDR_WIDTH-1:0];
            w_dat    <= pk_word;
            word_cnt <= word_cnt_nxt;
            if (word_cnt_nxt == len_words) begin
              state <= FINAL_STATE;
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        LDR_CHECK: begin
          if (accept) begin
            state <= (s_byte == checksum) ? LDR_DONE : LDR_ERROR;
          end
        end
`endif
        default: state <= LDR_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected BRAM writes,
// a negedge monitor pops and compares them whenever w_enb is seen.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int AW = 10;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    s_byte = 8'd0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [AW-1:0] w_addr;
  logic [31:0]   w_dat;
  logic          w_enb;
  logic [AW:0]   word_cnt;
  logic          cpu_hold;
  logic          done;
  logic          error;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_pulse = -1000;
  int   min_gap = 1000;
  wr_t  exp_q[$];
  wr_t  mon_e;
  logic [7:0]  bq[$];
  logic [7:0]  exp_cs;
  logic [31:0] prog[4] = '{32'h00500093, 32'h00A00113, 32'h002081B3, 32'h0000006F};

  imem_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(RAM_SIZE_WORDS)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .s_byte   (s_byte),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .w_addr   (w_addr),
    .w_dat    (w_dat),
    .w_enb    (w_enb),
    .word_cnt (word_cnt),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (w_enb) begin
      if (cyc - last_pulse < min_gap) min_gap = cyc - last_pulse;
      last_pulse = cyc;
      if (exp_q.size() == 0) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("[TB] FAIL unexpected_write got addr %0d data %h expected none", w_addr, w_dat);
      end else begin
        mon_e = exp_q.pop_front();
        check_output("w_addr", 32'(w_addr), 32'(mon_e.addr));
        check_output("w_dat", w_dat, mon_e.data);
      end
    end
  end

  task automatic apply_stimulus(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    @(negedge clk);
    s_byte  = b;
    s_valid = 1'b1;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("[TB] FAIL s_ready_timeout got 0 expected 1");
      s_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 s_valid = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic start_load();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Builds length + payload bytes for nwords of prog; expects the first nexp writes.
  task automatic build_image(input logic [31:0] len, input int nwords, input int nexp);
    logic [31:0] w;
    bq.delete();
    exp_cs = 8'd0;
    for (int i = 0; i < 4; i++) bq.push_back(len[8*i +: 8]);
    for (int i = 0; i < nwords; i++) begin
      w = prog[i];
      for (int j = 0; j < 4; j++) begin
        bq.push_back(w[8*j +: 8]);
        exp_cs = exp_cs + w[8*j +: 8];
      end
    end
    for (int i = 0; i < nexp; i++) exp_q.push_back('{addr: AW'(i), data: prog[i]});
  endtask

  task automatic send_bytes(input int count, input int gap);
    for (int i = 0; i < count; i++) apply_stimulus(bq[i], gap);
  endtask

  task automatic check_drained(input string name);
    repeat (2) @(posedge clk);
    #1 check_output(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_s_ready", 32'(s_ready), 32'd0);
    check_output("rst_w_enb", 32'(w_enb), 32'd0);
    check_output("rst_w_addr", 32'(w_addr), 32'd0);
    check_output("rst_w_dat", w_dat, 32'd0);
    check_output("rst_word_cnt", 32'(word_cnt), 32'd0);
    check_output("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_error", 32'(error), 32'd0);
    @(negedge clk) rst = 1'b1;

    // Four-word image, back-to-back bytes
    start_load();
    check_output("len_s_ready", 32'(s_ready), 32'd1);
    build_image(32'd4, 4, 4);
    send_bytes(20, 0);
`ifdef LOADER_CHECKSUM_EN
    check_output("pre_cs_done", 32'(done), 32'd0);
    apply_stimulus(exp_cs, 0);
`endif
    check_output("s1_done", 32'(done), 32'd1);
    check_output("s1_cpu_hold", 32'(cpu_hold), 32'd0);
    check_output("s1_error", 32'(error), 32'd0);
    check_output("s1_word_cnt", 32'(word_cnt), 32'd4);
    check_drained("s1_drained");
    @(negedge clk);
    s_valid = 1'b1;
    check_output("done_s_ready", 32'(s_ready), 32'd0);
    @(posedge clk);
    #1 s_valid = 1'b0;

    // Zero-length image
    start_load();
    check_output("restart_done", 32'(done), 32'd0);
    build_image(32'd0, 0, 0);
    send_bytes(4, 0);
`ifdef LOADER_CHECKSUM_EN
    check_output("len0_pre_cs", 32'(done), 32'd0);
    apply_stimulus(8'h00, 0);
`endif
    check_output("len0_done", 32'(done), 32'd1);
    check_output("len0_word_cnt", 32'(word_cnt), 32'd0);

    // Oversized length 0x401
    start_load();
    build_image(32'h0000_0401, 0, 0);
    send_bytes(4, 0);
    check_output("big_error", 32'(error), 32'd1);
    check_output("big_s_ready", 32'(s_ready), 32'd0);
    check_output("big_cpu_hold", 32'(cpu_hold), 32'd1);
    check_output("big_done", 32'(done), 32'd0);

    // Gapped stream, with a start pulse mid-load that must be ignored
    start_load();
    build_image(32'd4, 4, 4);
    last_pulse = -1000;
    min_gap = 1000;
    send_bytes(10, 3);
    start_load();
    for (int i = 10; i < 20; i++) apply_stimulus(bq[i], 3);
`ifdef LOADER_CHECKSUM_EN
    apply_stimulus(exp_cs, 0);
`endif
    check_output("gap_done", 32'(done), 32'd1);
    check_output("gap_word_cnt", 32'(word_cnt), 32'd4);
    check_output("gap_spacing_ge16", 32'(min_gap >= 16), 32'd1);
    check_drained("gap_drained");

`ifdef LOADER_CHECKSUM_EN
    // Wrong checksum byte after a full image
    start_load();
    build_image(32'd4, 4, 4);
    send_bytes(20, 0);
    apply_stimulus(8'h00, 0);
    check_output("badcs_error", 32'(error), 32'(exp_cs != 8'h00));
    check_output("badcs_done", 32'(done), 32'(exp_cs == 8'h00));
    check_drained("badcs_drained");
`endif

    // Reset after two words plus one byte, then a full reload
    start_load();
    build_image(32'd4, 4, 2);
    send_bytes(13, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    check_output("mid_rst_w_enb", 32'(w_enb), 32'd0);
    check_output("mid_rst_cpu_hold", 32'(cpu_hold), 32'd1);
    check_output("mid_rst_s_ready", 32'(s_ready), 32'd0);
    check_output("mid_rst_word_cnt", 32'(word_cnt), 32'd0);
    @(negedge clk) rst = 1'b1;
    check_drained("mid_rst_drained");
    start_load();
    build_image(32'd4, 4, 4);
    send_bytes(20, 0);
`ifdef LOADER_CHECKSUM_EN
    apply_stimulus(exp_cs, 0);
`endif
    check_output("reload_done", 32'(done), 32'd1);
    check_output("reload_word_cnt", 32'(word_cnt), 32'd4);
    check_drained("reload_drained");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
